// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory responder for the load/store stage.
// A byte-strobed store or a doubleword load completes against an internal array. The response follows after a fixed latency.
module dmem_resp #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LATENCY   = 1,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   input  logic [7:0]  req_wstrb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_rdata_o,
   output logic        rsp_err_o
);
   // state | meaning
   // IDLE  | no request outstanding, req_ready_o high
   // WAIT  | request accepted, latency counter running down
   // RESP  | response presented, held until rsp_ready_i

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned CW       = $clog2(LATENCY + 1);
   localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic           req_ready_q;
   logic           rsp_valid_q;
   logic [63:0]    rsp_rdata_q;
   logic           rsp_err_q;

   logic [63:0]    mem_q [DEPTH];

   logic [63:0]    offset;
   logic           in_range;
   logic [AW-1:0]  idx;
   logic           accept;

   assign offset   = req_addr_i - BASE_ADDR;
   assign in_range = (req_addr_i >= BASE_ADDR) && (offset < SPAN);
   assign idx      = offset[AW+2:3];
   assign accept   = req_valid_i & req_ready_q;

   // Array has no reset; a store accepted before a reset stays in place.
   always_ff @(posedge clk_i) begin
      if (accept && req_we_i && in_range) begin
         for (int b = 0; b < 8; b++) begin
            if (req_wstrb_i[b]) begin
               mem_q[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  rsp_rdata_q <= in_range ? mem_q[idx] : 64'd0;
                  rsp_err_q   <= ~in_range;
                  req_ready_q <= 1'b0;
                  if (LATENCY > 1) begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_ONE) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  cnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               cnt_q       <= '0;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the pipelined core's load/store stage: the target end of the memory interface that the load/store unit drives. Accepts one request at a time over a valid/ready handshake and performs a byte-strobed write or a doubleword read against an internal array. Returns the response over a second valid/ready handshake after a programmable latency. Replaces the zero-latency simulation memory model so the pipeline can be exercised against realistic memory timing.

## Interface
- DEPTH, 256, number of 64-bit doublewords in the array (power of two)
- LATENCY, 1, edges from request acceptance to `rsp_valid` assertion (≥1)
- BASE_ADDR, 64'h8000_0000, byte address mapped to doubleword 0
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  64  byte address; bits [2:0] ignored (doubleword aligned)
- req_wdata  input  64  store data, already lane-aligned by the requester
- req_wstrb  input  8  byte-lane write enables; bit i controls wdata[8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  64  doubleword contents before any write by this request
- rsp_err  output  1  address outside [BASE_ADDR, BASE_ADDR+8*DEPTH)

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- `req_ready` = 1 only in IDLE. Accept = `req_valid & req_ready`.
- Index = (req_addr − BASE_ADDR) >> 3, truncated to log2(DEPTH) bits after the range check. In range iff req_addr ≥ BASE_ADDR and (req_addr − BASE_ADDR) < 8*DEPTH.
- On the accept edge:
  - Read old doubleword into the response register, or 0 if out of range.
  - If `req_we` and in range, write the lanes with `req_wstrb`=1 and keep the other lanes.
  - `req_wstrb`=0 on a store leaves the array unchanged.
  - Latch `rsp_err`.
- Loads ignore `req_wdata`/`req_wstrb`. Out-of-range stores write nothing.
- IDLE → WAIT on accept if LATENCY>1. The counter loads LATENCY−1 and decrements each cycle.
- IDLE → RESP on accept if LATENCY=1.
- WAIT → RESP when the counter reaches 1 (that edge).
- RESP: `rsp_valid`=1. `rsp_rdata`/`rsp_err` held stable until `rsp_valid & rsp_ready`; that edge → IDLE.
- At most one outstanding request. No request queuing; `req_*` is ignored outside IDLE.
- Array contents are not reset. Simulation initialises them to 0.

## Timing
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Accept at edge T → `rsp_valid` high after edge T+LATENCY−1 (LATENCY=1: high in the cycle right after T).
- Response handshake at edge R → `req_ready` high after R. Next accept is possible at R+1.
- Minimum request-to-request spacing: LATENCY+1 cycles.
- A store's new data is visible to any later accepted load. There is no forwarding hazard, because only one request is in flight.
- `rsp_ready` held high before `rsp_valid`: the handshake completes on the first RESP edge.
- Reset asserted mid-operation (WAIT or RESP):
  - Outputs go to reset values immediately (asynchronous).
  - The pending response is discarded.
  - A write performed at acceptance remains in the array.
- `rsp_rdata` is registered: no combinational path from `req_*` to `rsp_*`.

## Test plan
- Full store then load, LATENCY=1:
  - Store: addr 8000_0010, wdata 1122334455667788, wstrb FF → rsp_rdata 0, rsp_err 0 one cycle after accept.
  - Load: same addr → rsp_rdata 1122334455667788.
- Byte strobe: preload 8000_0008 with FFFF_FFFF_FFFF_FFFF, store wdata 0000_0000_00AB_0000, wstrb 04 → the store's rsp_rdata is FFFF_FFFF_FFFF_FFFF; a load then returns FFFF_FFFF_FFAB_FFFF.
- Range error: load 7FFF_FFF8 and load 8000_0800 (DEPTH=256) → rsp_err 1, rsp_rdata 0; a store to 8000_0800 leaves index 0 unchanged.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid → rsp_valid, rsp_rdata, rsp_err stable; req_ready 0; a new req_valid is not accepted. rsp_ready=1 → req_ready 1 next cycle.
- LATENCY=3: accept at edge T → rsp_valid first seen high after edge T+2, low before. Back-to-back requests are accepted at most once every 4 cycles.
- Reset mid-op: in WAIT (LATENCY=3) after a store of 0000_0000_0000_00AA with wstrb 01 to 8000_0000, drop rst_n → rsp_valid 0 and req_ready 1 immediately; after release, a load of 8000_0000 returns ..._00AA.
